// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage front end for a word-addressed data memory.
// Handles byte/half/word loads and stores over valid/ready, turns sub-word stores
// into read-modify-write, extends loads, and flags misaligned/illegal/out-of-range
// requests. Optional statistics counters are built only when LSU_STATS_EN is defined.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_error,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  output logic             mem_write_enable,
  input  logic [31:0]      mem_read_data,
  output logic [CNT_W-1:0] stat_loads,
  output logic [CNT_W-1:0] stat_stores,
  output logic [CNT_W-1:0] stat_errors
);

  localparam int unsigned DW      = 32;
  localparam int unsigned WIDX_W  = 30;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;

  typedef struct packed {
    logic          write;
    logic [1:0]    size;
    logic          uns;
    logic [1:0]    lane;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        state_q, state_d;
  req_t          req_q, req_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic          resp_error_q, resp_error_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          accept_c;
  logic          req_err_c;
  logic [7:0]    ld_byte_c;
  logic [15:0]   ld_half_c;
  logic [DW-1:0] ld_ext_c;
  logic [DW-1:0] st_merge_c;

  assign accept_c  = req_valid && (state_q == ST_IDLE);
  assign req_err_c = (req_size == 2'b11)
                  || ((req_size == SZ_HALF) && req_addr[0])
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                  || (req_addr[31:2] >= WIDX_W'(MEM_WORDS));

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (req_err_c)                                 state_d = ST_RESP;
          else if (req_write && (req_size == SZ_WORD))   state_d = ST_WRITE;
          else                                           state_d = ST_READ;
        end
      end
      ST_READ:  state_d = req_q.write ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Load lane extraction/extension and sub-word store merge
  always_comb begin
    case (req_q.lane)
      2'd1:    ld_byte_c = mem_read_data[15:8];
      2'd2:    ld_byte_c = mem_read_data[23:16];
      2'd3:    ld_byte_c = mem_read_data[31:24];
      default: ld_byte_c = mem_read_data[7:0];
    endcase
    ld_half_c = req_q.lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (req_q.size)
      SZ_BYTE: ld_ext_c = {{24{~req_q.uns & ld_byte_c[7]}}, ld_byte_c};
      SZ_HALF: ld_ext_c = {{16{~req_q.uns & ld_half_c[15]}}, ld_half_c};
      default: ld_ext_c = mem_read_data;
    endcase
    st_merge_c = mem_read_data;
    if (req_q.size == SZ_BYTE) begin
      case (req_q.lane)
        2'd1:    st_merge_c[15:8]  = req_q.wdata[7:0];
        2'd2:    st_merge_c[23:16] = req_q.wdata[7:0];
        2'd3:    st_merge_c[31:24] = req_q.wdata[7:0];
        default: st_merge_c[7:0]   = req_q.wdata[7:0];
      endcase
    end else if (req_q.size == SZ_HALF) begin
      if (req_q.lane[1]) st_merge_c[31:16] = req_q.wdata[15:0];
      else               st_merge_c[15:0]  = req_q.wdata[15:0];
    end
  end

  // Output and datapath next values; write strobe defaults low so it lasts one cycle
  always_comb begin
    req_d        = req_q;
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          req_d.write = req_write;
          req_d.size  = req_size;
          req_d.uns   = req_unsigned;
          req_d.lane  = req_addr[1:0];
          req_d.wdata = req_wdata;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          if (req_err_c) begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = '0;
          end else if (req_write && (req_size == SZ_WORD)) begin
            mem_wdata_d = req_wdata;
            mem_we_d    = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (req_q.write) begin
          mem_wdata_d = st_merge_c;
          mem_we_d    = 1'b1;
        end else begin
          resp_valid_d = 1'b1;
          resp_rdata_d = ld_ext_c;
          resp_error_d = 1'b0;
        end
      end
      ST_WRITE: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_error_d = 1'b0;
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_error_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = resp_rdata_q;
  assign resp_error       = resp_error_q;
  assign mem_addr         = mem_addr_q;
  assign mem_write_data   = mem_wdata_q;
  assign mem_write_enable = mem_we_q;

`ifdef LSU_STATS_EN
  logic             resp_hs_c;
  logic [CNT_W-1:0] loads_q, stores_q, errors_q;

  assign resp_hs_c = (state_q == ST_RESP) && resp_ready;

  // Saturating completion counters, bumped on the response handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loads_q  <= '0;
      stores_q <= '0;
      errors_q <= '0;
    end else if (resp_hs_c) begin
      if (resp_error_q) begin
        if (errors_q != {CNT_W{1'b1}}) errors_q <= errors_q + CNT_W'(1);
      end else if (req_q.write) begin
        if (stores_q != {CNT_W{1'b1}}) stores_q <= stores_q + CNT_W'(1);
      end else begin
        if (loads_q != {CNT_W{1'b1}})  loads_q  <= loads_q + CNT_W'(1);
      end
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errors = errors_q;
`else
  assign stat_loads  = '0;
  assign stat_stores = '0;
  assign stat_errors = '0;
`endif

endmodule
